// File: rtl/immediate_encoder_pkg.sv
// Shared definitions for the immediate encoder.
//   - IMM_* immediate format codes (same values the immediate generator decodes)
//   - state_t: encoder FSM states
package immediate_encoder_pkg;

  localparam logic [2:0] IMM_ITYPE = 3'd0;
  localparam logic [2:0] IMM_STYPE = 3'd1;
  localparam logic [2:0] IMM_BTYPE = 3'd2;
  localparam logic [2:0] IMM_UTYPE = 3'd3;
  localparam logic [2:0] IMM_JTYPE = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    HOLD
  } state_t;

endpackage

// File: rtl/immediate_encoder_imm_scatter.sv
// imm_scatter: combinational inverse of the immediate generator.
// Range-checks a 32-bit immediate for the selected format and scatters its
// bits into the immediate slots of an instruction word.
//   immsel : immediate format (IMM_* code)
//   imm    : immediate value, two's complement
//   base   : instruction word with all immediate bit positions zero
//   data   : base OR scattered immediate; base unmodified on error
//   err    : immediate out of range, misaligned, or undefined format
module imm_scatter
  import immediate_encoder_pkg::*;
(
  input  logic [2:0]  immsel,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] data,
  output logic        err
);

  logic [31:0] field;

  always_comb begin
    field = '0;
    err   = 1'b0;
    case (immsel)
      IMM_ITYPE: begin
        field = {imm[11:0], 20'b0};
        err   = (imm[31:11] != {21{imm[11]}});
      end
      IMM_STYPE: begin
        field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        err   = (imm[31:11] != {21{imm[11]}});
      end
      IMM_BTYPE: begin
        field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        err   = (imm[31:12] != {20{imm[12]}}) || imm[0];
      end
      IMM_UTYPE: begin
        field = {imm[31:12], 12'b0};
        err   = (imm[11:0] != 12'b0);
      end
      IMM_JTYPE: begin
        field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        err   = (imm[31:20] != {12{imm[20]}}) || imm[0];
      end
      default: begin
        field = '0;
        err   = 1'b1;
      end
    endcase
    data = err ? base : (base | field);
  end

endmodule

// File: rtl/immediate_encoder.sv
// immediate_encoder: encodes immediates into instruction words for the
// program loader path, emitting them with a valid/ready handshake and an
// auto-incrementing instruction-memory word address.
//   I_clk, I_rst          : clock, asynchronous active-high reset
//   I_valid/O_ready       : request handshake (I_immsel, I_imm, I_base)
//   O_valid/I_ready       : result handshake (O_data, O_addr, O_err)
//   O_err_sticky          : set by any error result, cleared by I_clear/reset
//   I_clear               : synchronous clear of O_addr and O_err_sticky
module immediate_encoder
  import immediate_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_valid,
  output logic              O_ready,
  input  logic [2:0]        I_immsel,
  input  logic [31:0]       I_imm,
  input  logic [31:0]       I_base,
  output logic              O_valid,
  input  logic              I_ready,
  output logic [31:0]       O_data,
  output logic [ADDR_W-1:0] O_addr,
  output logic              O_err,
  output logic              O_err_sticky,
  input  logic              I_clear
);

  state_t      state;
  logic [2:0]  immsel_q;
  logic [31:0] imm_q;
  logic [31:0] base_q;
  logic [31:0] scat_data;
  logic        scat_err;

  imm_scatter u_scatter (
    .immsel (immsel_q),
    .imm    (imm_q),
    .base   (base_q),
    .data   (scat_data),
    .err    (scat_err)
  );

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state        <= IDLE;
      O_ready      <= 1'b1;
      O_valid      <= 1'b0;
      O_data       <= '0;
      O_addr       <= '0;
      O_err        <= 1'b0;
      O_err_sticky <= 1'b0;
      immsel_q     <= '0;
      imm_q        <= '0;
      base_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (I_valid) begin
            immsel_q <= I_immsel;
            imm_q    <= I_imm;
            base_q   <= I_base;
            O_ready  <= 1'b0;
            state    <= ENCODE;
          end
        end
        ENCODE: begin
          O_data  <= scat_data;
          O_err   <= scat_err;
          O_valid <= 1'b1;
          if (scat_err) O_err_sticky <= 1'b1;
          state   <= HOLD;
        end
        HOLD: begin
          if (I_ready) begin
            O_valid <= 1'b0;
            O_ready <= 1'b1;
            if (!O_err) O_addr <= O_addr + ADDR_W'(1);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a clear overrides a same-edge increment or sticky set.
      if (I_clear) begin
        O_addr       <= '0;
        O_err_sticky <= 1'b0;
      end
    end
  end

endmodule
